alu_share_arb: RTL and testbench

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

---
 rtl/alu_share_arb.sv | 155 +++++++++++++++
 tb/tb_alu_share_arb.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Arbitrates two requesters onto one shared combinational ALU: accept, execute, hold response.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 always wins contention.
module alu_share_arb (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [1:0]  req0_op,
   input  logic [5:0]  req0_fuc,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [1:0]  req1_op,
   input  logic [5:0]  req1_fuc,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_carry,
   output logic        rsp_ovf,
   output logic [1:0]  alu_op,
   output logic [5:0]  alu_fuc,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   input  logic        alu_carry,
   input  logic        alu_ovf,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic [1:0]  op_q, op_d;
   logic [5:0]  fuc_q, fuc_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] result_q, result_d;
   logic        zero_q, zero_d;
   logic        carry_q, carry_d;
   logic        ovf_q, ovf_d;
   logic        grant;
   logic        accept;
`ifdef ALU_ARB_RR_EN
   logic        rr_last_q, rr_last_d;
`endif

   // grant selects requester 1 when high; only meaningful while some request is valid
   always_comb begin
`ifdef ALU_ARB_RR_EN
      grant = (req0_valid && req1_valid) ? ~rr_last_q : ~req0_valid;
`else
      grant = ~req0_valid;
`endif
   end

   // Ready is gated by rst_n so that reset silences the handshake without waiting for a clock
   assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant;
   assign req1_ready = rst_n && (state_q == IDLE) && req1_valid && grant;
   assign accept     = req0_ready || req1_ready;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      op_d     = op_q;
      fuc_d    = fuc_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
`ifdef ALU_ARB_RR_EN
      rr_last_d = rr_last_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               owner_d = grant;
               op_d    = grant ? req1_op  : req0_op;
               fuc_d   = grant ? req1_fuc : req0_fuc;
               a_d     = grant ? req1_a   : req0_a;
               b_d     = grant ? req1_b   : req0_b;
               state_d = EXEC;
`ifdef ALU_ARB_RR_EN
               rr_last_d = grant;
`endif
            end
         end
         EXEC: begin
            result_d = alu_result;
            zero_d   = alu_zero;
            carry_d  = alu_carry;
            ovf_d    = alu_ovf;
            state_d  = RESP;
         end
         RESP: begin
            if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         op_q     <= 2'd0;
         fuc_q    <= 6'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         result_q <= 32'd0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef ALU_ARB_RR_EN
         rr_last_q <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         op_q     <= op_d;
         fuc_q    <= fuc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
`ifdef ALU_ARB_RR_EN
         rr_last_q <= rr_last_d;
`endif
      end
   end

   assign busy       = (state_q != IDLE);
   assign rsp0_valid = (state_q == RESP) && !owner_q;
   assign rsp1_valid = (state_q == RESP) && owner_q;
   assign rsp_result = result_q;
   assign rsp_zero   = zero_q;
   assign rsp_carry  = carry_q;
   assign rsp_ovf    = ovf_q;
   assign alu_op     = op_q;
   assign alu_fuc    = fuc_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb: behavioural ALU plus grant/result model, directed and random scenarios.
// Honours ALU_ARB_RR_EN the same way as the design.
module tb_alu_share_arb;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [1:0]  req0_op, req1_op;
   logic [5:0]  req0_fuc, req1_fuc;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp_result;
   logic        rsp_zero, rsp_carry, rsp_ovf;
   logic [1:0]  alu_op;
   logic [5:0]  alu_fuc;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        alu_zero, alu_carry, alu_ovf;
   logic        busy;

   int   n_cmp;
   int   n_bad;
   logic m_rr_last;

   alu_share_arb dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_fuc(req0_fuc), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_fuc(req1_fuc), .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf),
      .alu_op(alu_op), .alu_fuc(alu_fuc), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns {result, zero, carry, ovf}; op 00 add, 01 subtract, 10 by function field, 11 pass b
   function automatic logic [34:0] alu_fn(input logic [1:0] op, input logic [5:0] fuc,
                                          input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic        c, v;
      s = {1'b0, a} + {1'b0, b};
      r = s[31:0];
      c = s[32];
      v = (a[31] == b[31]) && (r[31] != a[31]);
      if (op == 2'b01 || (op == 2'b10 && fuc == 6'b100010)) begin
         s = {1'b0, a} - {1'b0, b};
         r = s[31:0];
         c = s[32];
         v = (a[31] != b[31]) && (r[31] != a[31]);
      end else if (op == 2'b10 && fuc == 6'b100100) begin
         r = a & b; c = 1'b0; v = 1'b0;
      end else if (op == 2'b10 && fuc == 6'b100101) begin
         r = a | b; c = 1'b0; v = 1'b0;
      end else if (op == 2'b10 && fuc == 6'b101010) begin
         r = {31'd0, $signed(a) < $signed(b)}; c = 1'b0; v = 1'b0;
      end else if (op == 2'b11) begin
         r = b; c = 1'b0; v = 1'b0;
      end
      return {r, (r == 32'd0), c, v};
   endfunction

   always_comb {alu_result, alu_zero, alu_carry, alu_ovf} = alu_fn(alu_op, alu_fuc, alu_a, alu_b);

   // Expected winner given the two valids; 1 means requester 1
   function automatic logic model_grant(input logic v0, input logic v1);
`ifdef ALU_ARB_RR_EN
      if (v0 && v1) return ~m_rr_last;
      return v1;
`else
      return !v0;
`endif
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic drive_req(input int n, input logic [1:0] op, input logic [5:0] fuc,
                            input logic [31:0] a, input logic [31:0] b);
      if (n == 0) begin
         req0_op = op; req0_fuc = fuc; req0_a = a; req0_b = b;
      end else begin
         req1_op = op; req1_fuc = fuc; req1_a = a; req1_b = b;
      end
   endtask

   task automatic rand_req(input int n);
      logic [5:0]  fuc;
      logic [31:0] a, b;
      case ($urandom_range(0, 5))
         0: fuc = 6'b100000;
         1: fuc = 6'b100010;
         2: fuc = 6'b100100;
         3: fuc = 6'b100101;
         4: fuc = 6'b101010;
         default: fuc = 6'($urandom);
      endcase
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      drive_req(n, 2'($urandom_range(0, 3)), fuc, a, b);
   endtask

   task automatic pulse_reset;
      clear_reqs();
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      m_rr_last = 1'b1;
   endtask

   task automatic test_reset;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      #2;
      n_cmp++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
         n_bad++;
         $display("[TB] FAIL reset_handshake: got %b expected 00000",
                  {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
      end
      n_cmp++;
      if ({alu_op, alu_fuc, alu_a, alu_b} !== 72'd0) begin
         n_bad++;
         $display("[TB] FAIL reset_alu: got %h expected 0", {alu_op, alu_fuc, alu_a, alu_b});
      end
      n_cmp++;
      if ({rsp_result, rsp_zero, rsp_carry, rsp_ovf} !== 35'd0) begin
         n_bad++;
         $display("[TB] FAIL reset_rsp: got %h expected 0", {rsp_result, rsp_zero, rsp_carry, rsp_ovf});
      end
      repeat (2) @(posedge clk);
      #1;
      clear_reqs();
      rst_n = 1'b1;
      m_rr_last = 1'b1;
   endtask

   task automatic test_add;
      drive_req(0, 2'b10, 6'b100000, 32'd5, 32'd7);
      req0_valid = 1'b1;
      #1;
      n_cmp++;
      if ({req1_ready, req0_ready} !== 2'b01) begin
         n_bad++;
         $display("[TB] FAIL add_accept: got %b expected 01", {req1_ready, req0_ready});
      end
      m_rr_last = 1'b0;
      tick();
      req0_valid = 1'b0;
      n_cmp++;
      if ({rsp0_valid, busy, alu_a, alu_b} !== {1'b0, 1'b1, 32'd5, 32'd7}) begin
         n_bad++;
         $display("[TB] FAIL add_exec: got %h expected %h", {rsp0_valid, busy, alu_a, alu_b},
                  {1'b0, 1'b1, 32'd5, 32'd7});
      end
      tick();
      n_cmp++;
      if ({rsp1_valid, rsp0_valid, rsp_result, rsp_zero, rsp_ovf} !== {1'b0, 1'b1, 32'd12, 1'b0, 1'b0}) begin
         n_bad++;
         $display("[TB] FAIL add_rsp: got %h expected %h",
                  {rsp1_valid, rsp0_valid, rsp_result, rsp_zero, rsp_ovf}, {1'b0, 1'b1, 32'd12, 1'b0, 1'b0});
      end
      tick();
      n_cmp++;
      if ({busy, rsp0_valid} !== 2'b00) begin
         n_bad++;
         $display("[TB] FAIL add_release: got %b expected 00", {busy, rsp0_valid});
      end
   endtask

   task automatic test_ovf;
      drive_req(1, 2'b10, 6'b100000, 32'h7FFF_FFFF, 32'd1);
      req1_valid = 1'b1;
      #1;
      n_cmp++;
      if ({req1_ready, req0_ready} !== 2'b10) begin
         n_bad++;
         $display("[TB] FAIL ovf_accept: got %b expected 10", {req1_ready, req0_ready});
      end
      m_rr_last = 1'b1;
      tick();
      req1_valid = 1'b0;
      tick();
      n_cmp++;
      if ({rsp1_valid, rsp0_valid, rsp_result, rsp_zero, rsp_carry, rsp_ovf} !==
          {1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1}) begin
         n_bad++;
         $display("[TB] FAIL ovf_rsp: got %h expected %h",
                  {rsp1_valid, rsp0_valid, rsp_result, rsp_zero, rsp_carry, rsp_ovf},
                  {1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1});
      end
      tick();
   endtask

   task automatic test_branch;
      drive_req(0, 2'b01, 6'b000000, 32'h1234, 32'h1234);
      req0_valid = 1'b1;
      #1;
      m_rr_last = 1'b0;
      tick();
      req0_valid = 1'b0;
      tick();
      n_cmp++;
      if ({rsp0_valid, rsp_result, rsp_zero, rsp_ovf} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin
         n_bad++;
         $display("[TB] FAIL branch_rsp: got %h expected %h", {rsp0_valid, rsp_result, rsp_zero, rsp_ovf},
                  {1'b1, 32'd0, 1'b1, 1'b0});
      end
      tick();
   endtask

   task automatic test_contention;
      logic        exp_g;
      logic [34:0] exp;
      int          waited;
      pulse_reset();
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      rand_req(0);
      rand_req(1);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         waited = 0;
         while (!(req0_ready || req1_ready) && waited < 8) begin
            tick();
            waited++;
         end
         n_cmp++;
         if (waited >= 8) begin
            n_bad++;
            $display("[TB] FAIL contention_timeout: got no grant expected grant %0d", k);
            break;
         end
         exp_g = model_grant(1'b1, 1'b1);
         if ({req1_ready, req0_ready} !== {exp_g, !exp_g}) begin
            n_bad++;
            $display("[TB] FAIL contention_grant: got %b expected %b", {req1_ready, req0_ready}, {exp_g, !exp_g});
         end
         exp = exp_g ? alu_fn(req1_op, req1_fuc, req1_a, req1_b) : alu_fn(req0_op, req0_fuc, req0_a, req0_b);
         m_rr_last = exp_g;
         tick();
         rand_req(0);
         rand_req(1);
         tick();
         n_cmp++;
         if ({rsp1_valid, rsp0_valid, rsp_result, rsp_zero, rsp_carry, rsp_ovf} !== {exp_g, !exp_g, exp}) begin
            n_bad++;
            $display("[TB] FAIL contention_rsp: got %h expected %h",
                     {rsp1_valid, rsp0_valid, rsp_result, rsp_zero, rsp_carry, rsp_ovf}, {exp_g, !exp_g, exp});
         end
      end
      clear_reqs();
      tick();
      tick();
   endtask

   task automatic test_back_pressure;
      logic [34:0] exp;
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b1;
      rand_req(0);
      req0_valid = 1'b1;
      req1_valid = 1'b0;
      #1;
      n_cmp++;
      if (req0_ready !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL bp_accept: got %b expected 1", req0_ready);
      end
      exp = alu_fn(req0_op, req0_fuc, req0_a, req0_b);
      m_rr_last = 1'b0;
      tick();
      req0_valid = 1'b0;
      rand_req(1);
      req1_valid = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({rsp0_valid, busy, req1_ready, rsp_result, rsp_zero, rsp_carry, rsp_ovf} !==
             {1'b1, 1'b1, 1'b0, exp}) begin
            n_bad++;
            $display("[TB] FAIL bp_hold: got %h expected %h",
                     {rsp0_valid, busy, req1_ready, rsp_result, rsp_zero, rsp_carry, rsp_ovf},
                     {1'b1, 1'b1, 1'b0, exp});
         end
         tick();
      end
      rsp0_ready = 1'b1;
      n_cmp++;
      if (req1_ready !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL bp_ack_cycle: got %b expected 0", req1_ready);
      end
      tick();
      n_cmp++;
      if ({rsp0_valid, req1_ready} !== 2'b01) begin
         n_bad++;
         $display("[TB] FAIL bp_resume: got %b expected 01", {rsp0_valid, req1_ready});
      end
      exp = alu_fn(req1_op, req1_fuc, req1_a, req1_b);
      m_rr_last = 1'b1;
      tick();
      req1_valid = 1'b0;
      tick();
      n_cmp++;
      if ({rsp1_valid, rsp_result, rsp_zero, rsp_carry, rsp_ovf} !== {1'b1, exp}) begin
         n_bad++;
         $display("[TB] FAIL bp_second_rsp: got %h expected %h",
                  {rsp1_valid, rsp_result, rsp_zero, rsp_carry, rsp_ovf}, {1'b1, exp});
      end
      tick();
   endtask

   task automatic test_reset_mid;
      logic [34:0] exp;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      rand_req(0);
      drive_req(0, 2'b00, 6'd0, req0_a | 32'h1, req0_b);
      req0_valid = 1'b1;
      #1;
      tick();
      clear_reqs();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, alu_op, alu_fuc, alu_a, alu_b} !== 77'd0) begin
         n_bad++;
         $display("[TB] FAIL midreset_async: got %h expected 0",
                  {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, alu_op, alu_fuc, alu_a, alu_b});
      end
      n_cmp++;
      if ({rsp_result, rsp_zero, rsp_carry, rsp_ovf} !== 35'd0) begin
         n_bad++;
         $display("[TB] FAIL midreset_rsp: got %h expected 0", {rsp_result, rsp_zero, rsp_carry, rsp_ovf});
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      m_rr_last = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
            n_bad++;
            $display("[TB] FAIL midreset_stale: got %b expected 000", {rsp0_valid, rsp1_valid, busy});
         end
         tick();
      end
      rand_req(1);
      req1_valid = 1'b1;
      #1;
      exp = alu_fn(req1_op, req1_fuc, req1_a, req1_b);
      m_rr_last = 1'b1;
      tick();
      clear_reqs();
      tick();
      n_cmp++;
      if ({rsp1_valid, rsp0_valid, rsp_result, rsp_zero, rsp_carry, rsp_ovf} !== {1'b1, 1'b0, exp}) begin
         n_bad++;
         $display("[TB] FAIL midreset_next: got %h expected %h",
                  {rsp1_valid, rsp0_valid, rsp_result, rsp_zero, rsp_carry, rsp_ovf}, {1'b1, 1'b0, exp});
      end
      tick();
   endtask

   task automatic test_random;
      logic        v0, v1, exp_g;
      logic [34:0] exp;
      int          delay;
      for (int it = 0; it < 60; it++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         if (!v0 && !v1) begin
            clear_reqs();
            #1;
            n_cmp++;
            if ({req1_ready, req0_ready, busy} !== 3'b000) begin
               n_bad++;
               $display("[TB] FAIL rand_idle: got %b expected 000", {req1_ready, req0_ready, busy});
            end
            tick();
            continue;
         end
         rand_req(0);
         rand_req(1);
         req0_valid = v0;
         req1_valid = v1;
         delay = $urandom_range(0, 3);
         #1;
         exp_g = model_grant(v0, v1);
         n_cmp++;
         if ({req1_ready, req0_ready} !== {exp_g, !exp_g}) begin
            n_bad++;
            $display("[TB] FAIL rand_grant: got %b expected %b", {req1_ready, req0_ready}, {exp_g, !exp_g});
         end
         exp = exp_g ? alu_fn(req1_op, req1_fuc, req1_a, req1_b) : alu_fn(req0_op, req0_fuc, req0_a, req0_b);
         m_rr_last = exp_g;
         rsp0_ready = exp_g ? 1'($urandom_range(0, 1)) : (delay == 0);
         rsp1_ready = exp_g ? (delay == 0) : 1'($urandom_range(0, 1));
         tick();
         rand_req(0);
         rand_req(1);
         tick();
         for (int d = 0; d <= delay; d++) begin
            if (d == delay) begin
               if (exp_g) rsp1_ready = 1'b1;
               else rsp0_ready = 1'b1;
            end
            n_cmp++;
            if ({req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp_result, rsp_zero, rsp_carry, rsp_ovf} !==
                {2'b00, exp_g, !exp_g, exp}) begin
               n_bad++;
               $display("[TB] FAIL rand_rsp: got %h expected %h",
                        {req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp_result, rsp_zero, rsp_carry, rsp_ovf},
                        {2'b00, exp_g, !exp_g, exp});
            end
            tick();
         end
      end
      clear_reqs();
      tick();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      m_rr_last = 1'b1;
      rst_n = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      drive_req(0, 2'b00, 6'd0, 32'd0, 32'd0);
      drive_req(1, 2'b00, 6'd0, 32'd0, 32'd0);
      test_reset();
      test_add();
      test_ovf();
      test_branch();
      test_contention();
      test_back_pressure();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
